// File: rtl/onchip_mem_burst_adapter.sv
// onchip_mem_burst_adapter: Avalon-MM burst slave in front of a single-port
// on-chip RAM. Splits single and incrementing bursts into one RAM access per
// cycle and generates s_waitrequest / s_readdatavalid for the CPU master.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a command; write beats posted directly from here
// ST_RBURST | issuing remaining read beats, master held off
// ST_WBURST | collecting remaining write beats, gaps allowed
`timescale 1ns/1ps
module onchip_mem_burst_adapter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32,
  parameter int BE_W    = 4,
  parameter int BURST_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  s_address,
  input  logic [BE_W-1:0]    s_byteenable,
  input  logic               s_read,
  input  logic               s_write,
  input  logic [DATA_W-1:0]  s_writedata,
  input  logic [BURST_W-1:0] s_burstcount,
  output logic               s_waitrequest,
  output logic [DATA_W-1:0]  s_readdata,
  output logic               s_readdatavalid,
  output logic [ADDR_W-1:0]  m_address,
  output logic [BE_W-1:0]    m_byteenable,
  output logic               m_chipselect,
  output logic               m_write,
  output logic [DATA_W-1:0]  m_writedata,
  input  logic [DATA_W-1:0]  m_readdata
);

  localparam int MAX_BURST = 1 << (BURST_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RBURST = 2'd1,
    ST_WBURST = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;    // address of the next beat to issue
  logic [BURST_W-1:0]  cnt_q, cnt_d;      // beats still to issue after the current one
  logic                rst_hold_q, rst_hold_d;
  logic [ADDR_W-1:0]   m_address_q, m_address_d;
  logic [BE_W-1:0]     m_byteenable_q, m_byteenable_d;
  logic                m_chipselect_q, m_chipselect_d;
  logic                m_write_q, m_write_d;
  logic [DATA_W-1:0]   m_writedata_q, m_writedata_d;
  logic                rdv_q, rdv_d;
  logic [BURST_W-1:0]  burst_len;

  // Normalise the requested burst length: 0 means 1, oversize clamps to MAX_BURST
  always_comb begin
    burst_len = s_burstcount;
    if (s_burstcount == '0) begin
      burst_len = BURST_W'(1);
    end else if (s_burstcount > BURST_W'(MAX_BURST)) begin
      burst_len = BURST_W'(MAX_BURST);
    end
  end

  // Next-state, beat sequencing and registered RAM command generation
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    rst_hold_d     = 1'b0;
    m_address_d    = m_address_q;
    m_byteenable_d = m_byteenable_q;
    m_writedata_d  = m_writedata_q;
    m_chipselect_d = 1'b0;
    m_write_d      = 1'b0;
    // Read data returns one cycle after the RAM sees the read address
    rdv_d          = m_chipselect_q & ~m_write_q;
    s_waitrequest  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Held off for one edge after reset so the master sees a clean start
        s_waitrequest = rst_hold_q;
        if (!rst_hold_q) begin
          // Write wins over a simultaneous read; the read is silently dropped
          if (s_write) begin
            m_chipselect_d = 1'b1;
            m_write_d      = 1'b1;
            m_address_d    = s_address;
            m_writedata_d  = s_writedata;
            m_byteenable_d = s_byteenable;
            addr_d         = s_address + 1'b1;
            cnt_d          = burst_len - 1'b1;
            if (burst_len > BURST_W'(1)) begin
              state_d = ST_WBURST;
            end
          end else if (s_read) begin
            m_chipselect_d = 1'b1;
            m_address_d    = s_address;
            m_byteenable_d = '1;
            addr_d         = s_address + 1'b1;
            cnt_d          = burst_len - 1'b1;
            state_d        = ST_RBURST;
          end
        end
      end

      ST_RBURST: begin
        s_waitrequest = 1'b1;
        if (cnt_q != '0) begin
          m_chipselect_d = 1'b1;
          m_address_d    = addr_q;
          m_byteenable_d = '1;
          addr_d         = addr_q + 1'b1;
          cnt_d          = cnt_q - 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WBURST: begin
        if (s_write) begin
          m_chipselect_d = 1'b1;
          m_write_d      = 1'b1;
          m_address_d    = addr_q;
          m_writedata_d  = s_writedata;
          m_byteenable_d = s_byteenable;
          addr_d         = addr_q + 1'b1;
          cnt_d          = cnt_q - 1'b1;
          if (cnt_q == BURST_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any burst in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      cnt_q          <= '0;
      rst_hold_q     <= 1'b1;
      m_address_q    <= '0;
      m_byteenable_q <= '0;
      m_chipselect_q <= 1'b0;
      m_write_q      <= 1'b0;
      m_writedata_q  <= '0;
      rdv_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      cnt_q          <= cnt_d;
      rst_hold_q     <= rst_hold_d;
      m_address_q    <= m_address_d;
      m_byteenable_q <= m_byteenable_d;
      m_chipselect_q <= m_chipselect_d;
      m_write_q      <= m_write_d;
      m_writedata_q  <= m_writedata_d;
      rdv_q          <= rdv_d;
    end
  end

  assign m_address       = m_address_q;
  assign m_byteenable    = m_byteenable_q;
  assign m_chipselect    = m_chipselect_q;
  assign m_write         = m_write_q;
  assign m_writedata     = m_writedata_q;
  assign s_readdatavalid = rdv_q;
  assign s_readdata      = m_readdata;

endmodule
